// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared types and RISC-V opcode constants for the immediate generator
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_IMM32 = 7'b0011011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP32     = 7'b0111011;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / decoded-immediate-out handshake bundle
interface imm_gen_pipe_if
    import imm_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] PC;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    fmt_e            fmt;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            illegal;

    modport master (
        output in_valid, inst, PC, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, fmt, imm, target, illegal
    );

    modport slave (
        input  in_valid, inst, PC, out_ready,
        output in_ready, out_valid, out_inst, out_pc, fmt, imm, target, illegal
    );
endinterface

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational format classify, immediate extract and PC-relative target
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    output fmt_e            fmt,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] target,
    output logic            illegal
);
    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_decode: XLEN must be 32 or 64");
        end
    endgenerate

    logic [XLEN-1:0] imm_i;
    logic            is_shift;
    logic            pc_rel;

    assign imm_i    = XLEN'($signed(inst[31:20]));
    // funct3 001 (sll) and 101 (srl/sra) share the low two bits
    assign is_shift = (inst[13:12] == 2'b01);

    always_comb begin
        fmt     = FMT_NONE;
        imm     = '0;
        illegal = 1'b1;
        pc_rel  = 1'b0;
        case (inst[6:0])
            OP_IMM: begin
                fmt     = FMT_I;
                illegal = 1'b0;
                if (is_shift)
                    imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
                else
                    imm = imm_i;
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    fmt     = FMT_I;
                    illegal = 1'b0;
                    imm     = is_shift ? XLEN'(inst[24:20]) : imm_i;
                end
            end
            LOAD, JALR, SYSTEM: begin
                fmt     = FMT_I;
                illegal = 1'b0;
                imm     = imm_i;
            end
            STORE: begin
                fmt     = FMT_S;
                illegal = 1'b0;
                imm     = XLEN'($signed({inst[31:25], inst[11:7]}));
            end
            BRANCH: begin
                fmt     = FMT_B;
                illegal = 1'b0;
                pc_rel  = 1'b1;
                imm     = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            end
            LUI, AUIPC: begin
                fmt     = FMT_U;
                illegal = 1'b0;
                pc_rel  = (inst[6:0] == AUIPC);
                imm     = XLEN'($signed({inst[31:12], 12'h000}));
            end
            JAL: begin
                fmt     = FMT_J;
                illegal = 1'b0;
                pc_rel  = 1'b1;
                imm     = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            end
            OP: begin
                fmt     = FMT_R;
                illegal = 1'b0;
            end
            OP32: begin
                if (XLEN == 64) begin
                    fmt     = FMT_R;
                    illegal = 1'b0;
                end
            end
            default: begin
                fmt     = FMT_NONE;
                illegal = 1'b1;
            end
        endcase
    end

    assign target = pc_rel ? (pc + imm) : '0;

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with 2-entry skid buffer
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    imm_gen_pipe_if.slave bus
);
    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        fmt_e            fmt;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    fmt_e            dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_target;
    logic            dec_illegal;
    entry_t          dec;
    entry_t          out_q;
    entry_t          skid_q;
    skid_state_e     state;
    logic            out_valid_q;
    logic            in_ready_q;
    logic            xfer_in;
    logic            xfer_out;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (bus.inst),
        .pc      (bus.PC),
        .fmt     (dec_fmt),
        .imm     (dec_imm),
        .target  (dec_target),
        .illegal (dec_illegal)
    );

    assign dec = {bus.inst, bus.PC, dec_fmt, dec_imm, dec_target, dec_illegal};

    // Without the skid entry the FSM never reaches TWO: in ONE, in_ready equals out_ready
    assign bus.in_ready = SKID ? in_ready_q : (!out_valid_q || bus.out_ready);
    assign xfer_in      = bus.in_valid && bus.in_ready;
    assign xfer_out     = out_valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        out_q       <= dec;
                        out_valid_q <= 1'b1;
                        state       <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (xfer_in && !xfer_out) begin
                        skid_q     <= dec;
                        in_ready_q <= 1'b0;
                        state      <= ST_TWO;
                    end else if (xfer_in) begin
                        out_q <= dec;
                    end else if (xfer_out) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (xfer_out) begin
                        out_q      <= skid_q;
                        in_ready_q <= 1'b1;
                        state      <= ST_ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= ST_EMPTY;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_q.inst;
    assign bus.out_pc    = out_q.pc;
    assign bus.fmt       = out_q.fmt;
    assign bus.imm       = out_q.imm;
    assign bus.target    = out_q.target;
    assign bus.illegal   = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed-vector bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64)) b64 ();

    imm_gen_pipe #(.XLEN(32), .SKID(1'b1)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .SKID(1'b1)) dut64 (.clk(clk), .rst(rst), .bus(b64));

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic vld, input logic [31:0] i, input logic [31:0] p);
        b32.in_valid = vld;
        b32.inst     = i;
        b32.PC       = p;
    endtask

    task automatic drive64(input logic vld, input logic [31:0] i, input logic [63:0] p);
        b64.in_valid = vld;
        b64.inst     = i;
        b64.PC       = p;
    endtask

    initial begin
        drive32(1'b0, 32'h0, 32'h0);
        drive64(1'b0, 32'h0, 64'h0);
        b32.out_ready = 1'b1;
        b64.out_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        check_eq("rst_out_valid", 64'(b32.out_valid), 64'd0);
        check_eq("rst_in_ready",  64'(b32.in_ready),  64'd1);
        check_eq("rst_imm",       64'(b32.imm),       64'd0);
        check_eq("rst_out_inst",  64'(b32.out_inst),  64'd0);
        check_eq("rst64_in_ready", 64'(b64.in_ready), 64'd1);

        // addi x5,x5,1
        drive32(1'b1, 32'h00128293, 32'h0000000C);
        step();
        check_eq("addi_valid",   64'(b32.out_valid), 64'd1);
        check_eq("addi_fmt",     64'(b32.fmt),       64'(FMT_I));
        check_eq("addi_imm",     64'(b32.imm),       64'h00000001);
        check_eq("addi_target",  64'(b32.target),    64'd0);
        check_eq("addi_illegal", 64'(b32.illegal),   64'd0);
        check_eq("addi_pc",      64'(b32.out_pc),    64'h0000000C);

        drive32(1'b1, 32'hFE000EE3, 32'h00000100);
        step();
        check_eq("beq_fmt",    64'(b32.fmt),      64'(FMT_B));
        check_eq("beq_imm",    64'(b32.imm),      64'hFFFFFFFC);
        check_eq("beq_target", 64'(b32.target),   64'h000000FC);
        check_eq("beq_inst",   64'(b32.out_inst), 64'hFE000EE3);

        drive32(1'b1, 32'hFF9FF06F, 32'h00000004);
        step();
        check_eq("jal_fmt",    64'(b32.fmt),    64'(FMT_J));
        check_eq("jal_imm",    64'(b32.imm),    64'hFFFFFFF8);
        check_eq("jal_target", 64'(b32.target), 64'hFFFFFFFC);

        drive32(1'b1, 32'h0000007F, 32'h00000200);
        step();
        check_eq("ill_valid",   64'(b32.out_valid), 64'd1);
        check_eq("ill_illegal", 64'(b32.illegal),   64'd1);
        check_eq("ill_fmt",     64'(b32.fmt),       64'(FMT_NONE));
        check_eq("ill_imm",     64'(b32.imm),       64'd0);
        check_eq("ill_target",  64'(b32.target),    64'd0);

        // addiw and slli-with-bit-25 behave differently on RV32
        drive32(1'b1, 32'h0000001B, 32'h0);
        step();
        check_eq("rv32_addiw_illegal", 64'(b32.illegal), 64'd1);
        drive32(1'b1, 32'h03F09093, 32'h0);
        step();
        check_eq("rv32_slli_imm", 64'(b32.imm), 64'd31);
        drive32(1'b1, 32'h12345017, 32'h00000010);
        step();
        check_eq("auipc_target", 64'(b32.target), 64'h12345010);
        drive32(1'b0, 32'h0, 32'h0);
        step();
        check_eq("drain_valid", 64'(b32.out_valid), 64'd0);

        // backpressure: A fills output, B fills skid, C must wait
        b32.out_ready = 1'b0;
        drive32(1'b1, 32'h00100093, 32'h00000010);
        step();
        check_eq("bp_ready_after_a", 64'(b32.in_ready), 64'd1);
        drive32(1'b1, 32'h00200113, 32'h00000014);
        step();
        check_eq("bp_ready_after_b", 64'(b32.in_ready), 64'd0);
        check_eq("bp_hold_inst_1",   64'(b32.out_inst), 64'h00100093);
        drive32(1'b1, 32'h00300193, 32'h00000018);
        step();
        check_eq("bp_hold_inst_2", 64'(b32.out_inst), 64'h00100093);
        check_eq("bp_hold_imm",    64'(b32.imm),      64'd1);
        check_eq("bp_hold_pc",     64'(b32.out_pc),   64'h00000010);
        b32.out_ready = 1'b1;
        step();
        check_eq("bp_out_b",       64'(b32.out_inst), 64'h00200113);
        check_eq("bp_ready_again", 64'(b32.in_ready), 64'd1);
        step();
        drive32(1'b0, 32'h0, 32'h0);
        check_eq("bp_out_c",     64'(b32.out_inst), 64'h00300193);
        check_eq("bp_out_c_imm", 64'(b32.imm),      64'd3);
        step();
        check_eq("bp_no_dup", 64'(b32.out_valid), 64'd0);

        // reset while both entries are full
        b32.out_ready = 1'b0;
        drive32(1'b1, 32'h00400213, 32'h00000020);
        step();
        drive32(1'b1, 32'h00500293, 32'h00000024);
        step();
        check_eq("two_in_ready", 64'(b32.in_ready), 64'd0);
        drive32(1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst2_out_valid", 64'(b32.out_valid), 64'd0);
        check_eq("rst2_in_ready",  64'(b32.in_ready),  64'd1);
        check_eq("rst2_out_inst",  64'(b32.out_inst),  64'd0);
        check_eq("rst2_imm",       64'(b32.imm),       64'd0);
        b32.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("rst2_no_ghost", 64'(b32.out_valid), 64'd0);
        end

        // RV64 vectors
        drive64(1'b1, 32'h80000037, 64'h0);
        step();
        check_eq("rv64_lui_fmt", 64'(b64.fmt), 64'(FMT_U));
        check_eq("rv64_lui_imm", b64.imm,      64'hFFFFFFFF80000000);
        drive64(1'b1, 32'h03F09093, 64'h0);
        step();
        check_eq("rv64_slli_imm", b64.imm, 64'd63);
        drive64(1'b1, 32'h0000001B, 64'h0);
        step();
        check_eq("rv64_addiw_fmt",     64'(b64.fmt),     64'(FMT_I));
        check_eq("rv64_addiw_illegal", 64'(b64.illegal), 64'd0);
        drive64(1'b1, 32'h0000003B, 64'h0);
        step();
        check_eq("rv64_op32_fmt", 64'(b64.fmt), 64'(FMT_R));
        drive64(1'b1, 32'hFF9FF06F, 64'h0000000000000004);
        step();
        check_eq("rv64_jal_target", b64.target, 64'hFFFFFFFFFFFFFFFC);
        drive64(1'b0, 32'h0, 64'h0);
        step();
        check_eq("rv64_drain", 64'(b64.out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised successor to the combinational Immediate block. It accepts one instruction/PC pair per cycle over a valid/ready handshake and classifies the format. It outputs the sign-extended XLEN immediate plus the PC-relative target, registered with one cycle of latency. A 2-entry skid buffer gives full throughput under backpressure. It sits between fetch and decode, and supports RV32I and RV64I (OP-IMM-32, 6-bit shamt).

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; other values are a compile-time error.
SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single register with in_ready = !out_valid || out_ready.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  instruction/PC pair offered
in_ready  output  1  block can accept this cycle
inst  input  32  instruction word
PC  input  XLEN  address of inst
out_valid  output  1  output fields valid
out_ready  input  1  consumer accepts this cycle
out_inst  output  32  registered copy of inst
out_pc  output  XLEN  registered copy of PC
fmt  output  3  format code (imm_pkg::fmt_e: R,I,S,B,U,J,NONE)
imm  output  XLEN  sign-extended immediate
target  output  XLEN  PC+imm for B, J, AUIPC; else 0
illegal  output  1  opcode not recognised for this XLEN

Behaviour:
- Reset (rst=1 at edge): out_valid=0, all data outputs 0, both entries empty, in_ready=1 from the cycle after. Reset mid-transfer discards all held entries; no output is produced for them.
- Transfer in: in_valid && in_ready at an edge. Transfer out: out_valid && out_ready at an edge.
- Latency: pair accepted at edge N is presented with out_valid=1 from edge N+1, provided the output register is empty or drains at N.
- Throughput: 1 per cycle while out_ready=1.
- While out_valid && !out_ready, all outputs hold stable.
- Order is strictly preserved.
- Skid buffer (SKID=1): states EMPTY, ONE (output register full), TWO (output and skid full).
  - in_ready=1 in EMPTY and ONE; in_ready=0 in TWO.
  - EMPTY -> ONE on transfer in.
  - ONE -> TWO on transfer in without transfer out.
  - ONE -> EMPTY on transfer out without transfer in.
  - ONE stays ONE on simultaneous transfer in and transfer out.
  - TWO -> ONE on transfer out; the skid entry moves to the output register.
- Decode on opcode inst[6:0]:
  - I: 0010011, 0000011, 1100111, 1110011, and 0011011 (only when XLEN=64).
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011, and 0111011 (only when XLEN=64); imm=0.
  - Anything else: fmt=NONE, illegal=1, imm=0, target=0.
- Immediates are sign-extended from the top instruction bit (inst[31]) to XLEN.
  - B immediate is 13 bits with LSB=0; J immediate is 21 bits with LSB=0.
  - U immediate is inst[31:12]<<12, sign-extended (matters for XLEN=64).
- Shift immediates (opcode 0010011, funct3 001/101): imm is the zero-extended shamt.
  - XLEN=32: inst[24:20].
  - XLEN=64: inst[25:20].
  - Opcode 0011011: inst[24:20].
- target = PC+imm modulo 2^XLEN (wraps, no flag) for B, J and AUIPC (0010111). JALR and all other formats: target=0.
- Decode is computed at the input; its results are registered together with inst/PC.

Decomposition:
- Package imm_pkg: fmt_e enum, opcode localparams (OP_IMM, OP_IMM32, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, OP, OP32).
- Sub-module imm_decode: combinational, parametrised by XLEN; produces fmt/imm/target/illegal from inst and PC.
- imm_gen_pipe instantiates imm_decode and owns the skid-buffer FSM.

Test Plan:
- XLEN=32: inst=0x00128293, PC=0x0000000C, out_ready=1 -> next cycle out_valid=1, fmt=I, imm=0x00000001, target=0, illegal=0.
- inst=0xFE000EE3 (beq -4), PC=0x100 -> fmt=B, imm=0xFFFFFFFC, target=0x000000FC. Then inst=0xFF9FF06F (jal -8), PC=0x4 -> fmt=J, imm=0xFFFFFFF8, target=0xFFFFFFFC (wrap).
- Backpressure: stream 3 instrs with out_ready=0 -> in_ready=0 after 2 accepted, outputs stable. Raise out_ready -> all 3 emerge in order on consecutive cycles, none lost or duplicated.
- Reset with state TWO: assert rst one cycle -> next cycle out_valid=0, in_ready=1, outputs 0; the two held instructions never appear.
- inst=0x0000007F -> illegal=1, fmt=NONE, imm=0, target=0; the handshake still completes normally.
- XLEN=64: inst=0x80000037 -> imm=0xFFFFFFFF80000000. inst=0x03F09093 (slli x1,x1,63) -> imm=63. inst=0x0000001B (addiw) -> fmt=I, illegal=0.
